// File: rtl/shift_rotate_unit_if.sv
// Start/done handshake bundle between the accumulator controller and the shift/rotate engine.
// The master side issues requests; the slave side returns the result and flags.
interface shift_rotate_unit_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
);
   logic             start;
   logic [2:0]       op;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] data_in;
   logic             carry_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] data_out;
   logic             carry_out;
   logic             zero_out;

   modport master (
      output start, op, count, data_in, carry_in,
      input  busy, done, data_out, carry_out, zero_out
   );

   modport slave (
      input  start, op, count, data_in, carry_in,
      output busy, done, data_out, carry_out, zero_out
   );
endinterface

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate engine: one bit-step per clock over a programmable count.
// Result, carry and zero flag are working registers, valid while done is high.
module shift_rotate_unit #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic                i_clk,
   input  logic                i_reset,
   shift_rotate_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   logic             r_carry;
   logic             r_zero;
   logic [2:0]       r_op;
   logic [CNT_W-1:0] r_remain;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH:0]   w_step;

   // One single-bit step; returns {new_carry, new_data}.
   function automatic logic [WIDTH:0] step_fn(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] d,
      input logic             c
   );
      logic [WIDTH:0] r;
      case (op)
         3'b000:  r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
         3'b001:  r = {d[0], 1'b0, d[WIDTH-1:1]};
         3'b010:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
         3'b011:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
         3'b100:  r = {d[0], d[0], d[WIDTH-1:1]};
         3'b101:  r = {d[WIDTH-1], d[WIDTH-2:0], c};
         3'b110:  r = {d[0], c, d[WIDTH-1:1]};
         default: r = {c, d};
      endcase
      return r;
   endfunction

   assign w_step = step_fn(r_op, r_data, r_carry);

   // Control FSM and working registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_data   <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b1;
         r_op     <= 3'b000;
         r_remain <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_data  <= bus.data_in;
                  r_carry <= bus.carry_in;
                  r_zero  <= (bus.data_in == '0);
                  r_op    <= bus.op;
                  // NOP and zero counts skip SHIFT and return the operands unchanged.
                  if ((bus.count != '0) && (bus.op != 3'b111)) begin
                     r_remain <= bus.count;
                     r_busy   <= 1'b1;
                     r_state  <= S_SHIFT;
                  end else begin
                     r_remain <= '0;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               r_data   <= w_step[WIDTH-1:0];
               r_carry  <= w_step[WIDTH];
               r_zero   <= (w_step[WIDTH-1:0] == '0);
               r_remain <= r_remain - CNT_W'(1);
               if (r_remain == CNT_W'(1)) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_state <= S_SHIFT;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.data_out  = r_data;
   assign bus.carry_out = r_carry;
   assign bus.zero_out  = r_zero;

endmodule
